// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue
//   Decoupling FIFO between the fetch controller and the issue stage. Each
//   entry holds instruction, PC, predicted-taken flag and predicted target.
//   The oldest entry is presented to issue with a valid/ready handshake, and
//   the whole queue is discarded on a pipeline flush.
//
//   Optional build macro: FIQ_BYPASS_EN
//     When defined, an entry arriving at an empty queue while issue is ready
//     (and no flush) passes combinationally to the outputs and is consumed
//     without being written. When undefined there is no path from input data
//     to output data and the minimum latency is one cycle.
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   flush_i               discard all entries; blocks push/pop this cycle
//   fetch_valid_i/ready_o fetch-side handshake; ready depends on state only
//   instr_i, pc_i,
//   pred_taken_i,
//   pred_target_i         entry written on push
//   issue_valid_o/ready_i issue-side handshake
//   instr_o, pc_o,
//   pred_taken_o,
//   pred_target_o         head entry (don't-care while issue_valid_o = 0)
//   count_o               occupancy, 0..DEPTH
module fetch_issue_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  output logic                     fetch_ready_o,
  input  logic [ILEN-1:0]          instr_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     pred_taken_i,
  input  logic [XLEN-1:0]          pred_target_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [ILEN-1:0]          instr_o,
  output logic [XLEN-1:0]          pc_o,
  output logic                     pred_taken_o,
  output logic [XLEN-1:0]          pred_target_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ILEN-1:0] instr_mem  [DEPTH];
  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic            taken_mem  [DEPTH];
  logic [XLEN-1:0] target_mem [DEPTH];

  // MSB of each pointer is the wrap bit; it tells full from empty when the
  // index bits match.
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, bypass, push, pop;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

`ifdef FIQ_BYPASS_EN
  assign bypass = empty & fetch_valid_i & issue_ready_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Ready is purely state-based so a pop cannot free a slot for a push in
  // the same cycle; this keeps issue_ready_i off the fetch timing path.
  assign fetch_ready_o = ~full & ~flush_i;
  assign issue_valid_o = (~empty | bypass) & ~flush_i;

  // A bypassed entry is consumed directly and never touches storage.
  assign push = fetch_valid_i & fetch_ready_o & ~bypass;
  assign pop  = issue_valid_o & issue_ready_i & ~bypass;

  assign count_o = wr_ptr - rd_ptr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr[AW-1:0]]  <= instr_i;
      pc_mem[wr_ptr[AW-1:0]]     <= pc_i;
      taken_mem[wr_ptr[AW-1:0]]  <= pred_taken_i;
      target_mem[wr_ptr[AW-1:0]] <= pred_target_i;
    end
  end

  always_comb begin
    instr_o       = instr_mem[rd_ptr[AW-1:0]];
    pc_o          = pc_mem[rd_ptr[AW-1:0]];
    pred_taken_o  = taken_mem[rd_ptr[AW-1:0]];
    pred_target_o = target_mem[rd_ptr[AW-1:0]];
    if (bypass) begin
      instr_o       = instr_i;
      pc_o          = pc_i;
      pred_taken_o  = pred_taken_i;
      pred_target_o = pred_target_i;
    end
  end

endmodule

// File: tb/tb_fetch_issue_queue.sv
module tb_fetch_issue_queue;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        pred_taken_i;
  logic [31:0] pred_target_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic [3:0]  count_o;

  int errors = 0;
  int checks = 0;

  fetch_issue_queue #(.DEPTH(8), .XLEN(32), .ILEN(32)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .pred_taken_i  (pred_taken_i),
    .pred_target_i (pred_target_i),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_entry(input int n);
    pc_i          = 32'(n * 4);
    instr_i       = 32'hA000 + 32'(n);
    pred_taken_i  = n[0];
    pred_target_i = 32'h1000 + 32'(n);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0; issue_ready_i = 1'b0;
    set_entry(0);
    #1;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b expected 0", issue_valid_o); end
    tick();
    rst_n_i = 1'b1;
    #1;
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_fetch_ready: got %b expected 1", fetch_ready_o); end
  endtask

  task automatic test_fill();
    issue_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fetch_valid_i = 1'b1; set_entry(i);
      #1;
      checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b expected 1", i, fetch_ready_o); end
      tick();
    end
    set_entry(8);
    #1;
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", count_o); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b expected 0", fetch_ready_o); end
    checks++; if (issue_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'hA000)
      begin errors++; $display("FAIL fill_head: got v=%b pc=%0h instr=%0h expected v=1 pc=0 instr=a000", issue_valid_o, pc_o, instr_o); end
    tick();
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fill_held: got %0d expected 8", count_o); end
  endtask

  task automatic test_full_pop();
    issue_ready_i = 1'b1;
    #1;
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL fullpop_ready: got %b expected 0", fetch_ready_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL fullpop_pc: got %0h expected 0", pc_o); end
    tick();
    issue_ready_i = 1'b0; fetch_valid_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd7) begin errors++; $display("FAIL fullpop_count: got %0d expected 7", count_o); end
    checks++; if (pc_o !== 32'h4 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h1001)
      begin errors++; $display("FAIL fullpop_next: got pc=%0h t=%b tgt=%0h expected pc=4 t=1 tgt=1001", pc_o, pred_taken_o, pred_target_o); end
    issue_ready_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      #1;
      checks++; if (issue_valid_o !== 1'b1 || pc_o !== 32'(i * 4))
        begin errors++; $display("FAIL drain_%0d: got v=%b pc=%0h expected v=1 pc=%0h", i, issue_valid_o, pc_o, i * 4); end
      tick();
    end
    issue_ready_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0)
      begin errors++; $display("FAIL drain_empty: got count=%0d v=%b expected 0 0", count_o, issue_valid_o); end
  endtask

  task automatic test_wrap();
    int p = 0, h = 0, k = 0, ec = 0;
    bit byp, do_push, do_pop;
    while ((p < 20 || h < 20) && k < 200) begin
      fetch_valid_i = (p < 20);
      set_entry(p);
      issue_ready_i = (k % 2 == 0);
      #1;
`ifdef FIQ_BYPASS_EN
      byp = (ec == 0) && fetch_valid_i && issue_ready_i;
`else
      byp = 1'b0;
`endif
      checks++; if (count_o !== 4'(ec)) begin errors++; $display("FAIL wrap_count_k%0d: got %0d expected %0d", k, count_o, ec); end
      if (byp) begin
        checks++; if (issue_valid_o !== 1'b1 || pc_o !== 32'(p * 4))
          begin errors++; $display("FAIL wrap_bypass_k%0d: got v=%b pc=%0h expected v=1 pc=%0h", k, issue_valid_o, pc_o, p * 4); end
        p++; h++;
      end else begin
        if (ec > 0) begin
          checks++; if (issue_valid_o !== 1'b1 || pc_o !== 32'(h * 4))
            begin errors++; $display("FAIL wrap_head_k%0d: got v=%b pc=%0h expected v=1 pc=%0h", k, issue_valid_o, pc_o, h * 4); end
        end else begin
          checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_empty_k%0d: got v=%b expected 0", k, issue_valid_o); end
        end
        do_push = fetch_valid_i && (ec < 8);
        do_pop  = issue_ready_i && (ec > 0);
        if (do_push) begin p++; ec++; end
        if (do_pop)  begin h++; ec--; end
      end
      tick();
      k++;
    end
    fetch_valid_i = 1'b0; issue_ready_i = 1'b0;
    checks++; if (k >= 200) begin errors++; $display("FAIL wrap_timeout: got %0d cycles expected under 200", k); end
    #1;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL wrap_final_count: got %0d expected 0", count_o); end
  endtask

  task automatic test_flush();
    issue_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fetch_valid_i = 1'b1; set_entry(32 + i);
      tick();
    end
    fetch_valid_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", count_o); end
    flush_i = 1'b1; fetch_valid_i = 1'b1; issue_ready_i = 1'b1; set_entry(40);
    #1;
    checks++; if (fetch_ready_o !== 1'b0 || issue_valid_o !== 1'b0)
      begin errors++; $display("FAIL flush_same_cycle: got ready=%b v=%b expected 0 0", fetch_ready_o, issue_valid_o); end
    tick();
    flush_i = 1'b0; fetch_valid_i = 1'b0; issue_ready_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0)
      begin errors++; $display("FAIL flush_after: got count=%0d v=%b expected 0 0", count_o, issue_valid_o); end
  endtask

  task automatic test_latency();
    fetch_valid_i = 1'b1; issue_ready_i = 1'b1;
    pc_i = 32'h100; instr_i = 32'hC0DE; pred_taken_i = 1'b0; pred_target_i = 32'h0;
    #1;
`ifdef FIQ_BYPASS_EN
    checks++; if (issue_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'hC0DE)
      begin errors++; $display("FAIL bypass_same_cycle: got v=%b pc=%0h instr=%0h expected 1 100 c0de", issue_valid_o, pc_o, instr_o); end
    tick();
    fetch_valid_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0)
      begin errors++; $display("FAIL bypass_after: got count=%0d v=%b expected 0 0", count_o, issue_valid_o); end
`else
    checks++; if (issue_valid_o !== 1'b0) begin errors++; $display("FAIL lat_same_cycle: got v=%b expected 0", issue_valid_o); end
    tick();
    fetch_valid_i = 1'b0;
    #1;
    checks++; if (issue_valid_o !== 1'b1 || pc_o !== 32'h100 || count_o !== 4'd1)
      begin errors++; $display("FAIL lat_next_cycle: got v=%b pc=%0h count=%0d expected 1 100 1", issue_valid_o, pc_o, count_o); end
    tick();
    #1;
    checks++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0)
      begin errors++; $display("FAIL lat_drained: got count=%0d v=%b expected 0 0", count_o, issue_valid_o); end
`endif
    issue_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_valid_i = 1'b1; set_entry(48 + i);
      tick();
    end
    fetch_valid_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 3", count_o); end
    #1;
    rst_n_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd0 || issue_valid_o !== 1'b0)
      begin errors++; $display("FAIL rstmid_async: got count=%0d v=%b expected 0 0", count_o, issue_valid_o); end
    tick();
    rst_n_i = 1'b1;
    #1;
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", fetch_ready_o); end
    fetch_valid_i = 1'b1; pc_i = 32'h500;
    tick();
    fetch_valid_i = 1'b0;
    #1;
    checks++; if (issue_valid_o !== 1'b1 || pc_o !== 32'h500 || count_o !== 4'd1)
      begin errors++; $display("FAIL rstmid_resume: got v=%b pc=%0h count=%0d expected 1 500 1", issue_valid_o, pc_o, count_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_wrap();
    test_flush();
    test_latency();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
